bitwise_pipe: RTL

BITWISE_PIPE -- requirements
Module: bitwise_pipe

---
 rtl/bitwise_pipe.sv | 86 ++++++++
 1 files changed

// File: rtl/bitwise_pipe.sv
// rtl/bitwise_pipe.sv - bitwise logic unit with a 2-entry in-order result buffer
// Results and their zero/negative flags are computed at accept time and stored.
module bitwise_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zr,
   output logic             out_ng
);

   logic [WIDTH-1:0] r_data [2];
   logic [1:0]       r_zr;
   logic [1:0]       r_ng;
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_count;
   logic             r_live;

   logic [WIDTH-1:0] w_result;
   logic             w_push;
   logic             w_pop;

   always_comb begin
      w_result = '0;
      case (in_op)
         3'b000: w_result = ~in_a;
         3'b001: w_result = in_a & in_b;
         3'b010: w_result = in_a | in_b;
         3'b011: w_result = in_a ^ in_b;
         3'b100: w_result = ~(in_a & in_b);
         3'b101: w_result = ~(in_a | in_b);
         3'b110: w_result = ~(in_a ^ in_b);
         3'b111: w_result = in_a;
         default: w_result = '0;
      endcase
   end

   // r_live holds in_ready low until the first edge after reset release.
   assign in_ready  = r_live && (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign out_data = out_valid ? r_data[r_rptr] : '0;
   assign out_zr   = out_valid ? r_zr[r_rptr] : 1'b1;
   assign out_ng   = out_valid ? r_ng[r_rptr] : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_zr      <= 2'b11;
         r_ng      <= 2'b00;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_count   <= 2'd0;
         r_live    <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push) begin
            r_data[r_wptr] <= w_result;
            r_zr[r_wptr]   <= (w_result == '0);
            r_ng[r_wptr]   <= w_result[WIDTH-1];
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
